// File: rtl/ram_port_arbiter.sv
// Arbiter in front of the single-port 64x16 program/data RAM.
// Port A is the UART boot loader and port B is the CPU. Round-robin
// arbitration is used in RUN. The CPU can hold the RAM for read-modify-write
// (LOCK_B). While BOOT is active, only the loader is served and the CPU is
// stalled.
//
// Handshake: a port raises req and holds adr/we/wdata stable. A transfer
// happens at the rising edge where req & gnt & ce are all 1. gnt is
// combinational from the registered state and the current reqs, so a
// requester must not make req depend on gnt. For a read, the port's rvalid
// is 1 in the following cycle and rdata then carries the RAM output.
module ram_port_arbiter #(
  parameter int ADR_W    = 6,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              boot,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADR_W-1:0]  a_adr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADR_W-1:0]  b_adr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADR_W-1:0]  ram_adr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              cpu_stall,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOCK_B = 2'd1,
    BOOT   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             rr_a, rr_a_nx;          // 1: A wins a tie, 0: B wins a tie
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nx;
  logic             a_xfer, b_xfer;

  assign state_dbg = state;
  assign cpu_stall = (state == BOOT);
  assign rdata     = ram_out;
  assign a_xfer    = a_req & a_gnt;
  assign b_xfer    = b_req & b_gnt;

  // Grant decision. Reset and ce=0 block every grant. boot is not an input here.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (ce && !rst) begin
      case (state)
        RUN: begin
          if (a_req && b_req) begin
            a_gnt = rr_a;
            b_gnt = ~rr_a;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
        LOCK_B:  b_gnt = b_req;
        BOOT:    a_gnt = a_req;
        default: ;
      endcase
    end
  end

  // Route the granted port to the RAM. Drive zeros when the RAM is idle.
  always_comb begin
    ram_enable = a_gnt | b_gnt;
    ram_rw     = 1'b0;
    ram_adr    = '0;
    ram_in     = '0;
    if (a_gnt) begin
      ram_rw  = a_we;
      ram_adr = a_adr;
      ram_in  = a_wdata;
    end else if (b_gnt) begin
      ram_rw  = b_we;
      ram_adr = b_adr;
      ram_in  = b_wdata;
    end
  end

  // Next state, round-robin pointer and lock counter.
  always_comb begin
    state_nx    = state;
    rr_a_nx     = rr_a;
    lock_cnt_nx = lock_cnt;
    case (state)
      RUN: begin
        if (a_xfer) rr_a_nx = 1'b0;
        if (b_xfer) rr_a_nx = 1'b1;
        if (boot) begin
          // Boot takes priority over a lock request. The B transfer in this
          // cycle still completes.
          state_nx = BOOT;
        end else if (b_xfer && b_lock) begin
          if (LOCK_MAX > 1) begin
            state_nx    = LOCK_B;
            lock_cnt_nx = CNT_W'(1);
          end
        end
      end
      LOCK_B: begin
        // A pending boot request waits here until the lock is released.
        if (b_xfer) begin
          if (!b_lock || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            state_nx    = RUN;
            rr_a_nx     = 1'b1;
            lock_cnt_nx = '0;
          end else begin
            lock_cnt_nx = lock_cnt + CNT_W'(1);
          end
        end
      end
      BOOT: begin
        if (!boot) begin
          state_nx = RUN;
          rr_a_nx  = 1'b0;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // State registers. They advance only on edges where ce=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      rr_a     <= 1'b0;
      lock_cnt <= '0;
    end else if (ce) begin
      state    <= state_nx;
      rr_a     <= rr_a_nx;
      lock_cnt <= lock_cnt_nx;
    end
  end

  // Read-valid strobes line up with the RAM output one cycle after a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else if (ce) begin
      a_rvalid <= a_xfer & ~a_we;
      b_rvalid <= b_xfer & ~b_we;
    end
  end

endmodule
